// File: rtl/seq_restoring_divider.sv
// Iterative unsigned radix-2 restoring divider: one quotient bit per clock,
// valid/ready request channel in, valid/ready result channel out.
module seq_restoring_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q,     state_d;
  logic [DATA_WIDTH-1:0] rem_q,       rem_d;
  logic [DATA_WIDTH-1:0] shq_q,       shq_d;
  logic [DATA_WIDTH-1:0] dvs_q,       dvs_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0] quotient_q,  quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  dbz_q,       dbz_d;

  // The partial remainder never reaches the divisor, so it is stored in
  // DATA_WIDTH bits; only the trial difference needs the extra sign bit.
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;
  logic                  trial_neg;

  assign shifted   = {rem_q, shq_q[DATA_WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign trial_neg = trial[DATA_WIDTH];

  assign start_ready = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    rem_d       = rem_q;
    shq_d       = shq_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          dvs_d = divisor;
          shq_d = dividend;
          rem_d = '0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            cnt_d   = CNT_W'(DATA_WIDTH - 1);
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (trial_neg) begin
          rem_d = shifted[DATA_WIDTH-1:0];
          shq_d = {shq_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
          rem_d = trial[DATA_WIDTH-1:0];
          shq_d = {shq_q[DATA_WIDTH-2:0], 1'b1};
        end
        if (cnt_q == '0) begin
          // Results are published only on the last step so the visible
          // outputs keep their previous values throughout the iteration.
          quotient_d  = shq_d;
          remainder_d = rem_d;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      shq_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      rem_q       <= rem_d;
      shq_q       <= shq_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

endmodule
